fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the echo sample FIFO. It monitors the FIFO occupancy, pops samples in fixed-length bursts, and absorbs the FIFO's one-cycle read latency. Samples go out on a valid/ready stream with a per-burst last flag, so downstream beamforming logic receives aligned sample groups. It pairs with the FIFO's write side and consumes what the front-end writer pushes.

## Interface
- DATA_WIDTH, 16, sample width.
- ADDR_WIDTH, 3, FIFO address width; FIFO depth = 2^ADDR_WIDTH.
- BURST_LEN, 4, samples per burst; legal range 1..2^ADDR_WIDTH.
- TIMEOUT_CYC, 64, idle cycles before a partial burst is flushed; used only with FIFO_BURST_READER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fifo_count  in  ADDR_WIDTH+1  FIFO occupancy; already decremented for a pop sampled at the same edge.
- fifo_rd_en  out  1  pop request, sampled by FIFO at rising edge.
- fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after the edge that sampled fifo_rd_en.
- m_data  out  DATA_WIDTH  output sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  qualifies the final sample of a burst.
- burst_active  out  1  high in READ and FLUSH.
- bursts_done  out  16  count of completed bursts; wraps at 2^16.

## Operation
- States: IDLE, READ, FLUSH. Reset state IDLE.
- IDLE -> READ when fifo_count >= BURST_LEN. Latch burst_len_q = BURST_LEN and clear pop counter.
- READ: fifo_rd_en = fifo_count != 0 && pops < burst_len_q && (occ - (m_valid && m_ready) + inflight) < 2.
  - occ is the output buffer occupancy, 0..2.
  - inflight is the fifo_rd_en registered from the previous cycle.
- READ -> FLUSH on the edge where the last pop is sampled.
- FLUSH -> IDLE on the edge where the sample carrying m_last is accepted. Increment bursts_done on that same edge.
- Output buffer: 2-entry skid queue. Capture fifo_data when inflight = 1. m_data/m_valid come from the head entry.
- m_last is high when the head entry is sample number burst_len_q of the burst.
- Stream rules:
  - m_data, m_valid and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without acceptance.
  - No sample is dropped or duplicated.
- fifo_rd_en is never asserted when fifo_count == 0 (no underflow).
- Pop counter width is ADDR_WIDTH+1.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, burst_active=0, bursts_done=0; occupancy, inflight and counters are 0.
- Reset mid-burst: return to IDLE at once. Buffered and in-flight samples are discarded. The FIFO is not rewound.
- Latency: let E0 be the edge where IDLE sees fifo_count >= BURST_LEN.
  - fifo_rd_en is high in the cycle after E0.
  - The first m_valid appears after E0+2.
- Throughput: with m_ready held high and data available, one sample per cycle. A burst of N samples spans N consecutive m_valid cycles.
- Backpressure: a deassertion of m_ready blocks further pops within one cycle. At most 2 samples are outstanding (buffered plus in flight).
- Back-to-back bursts: a new burst may start at the FLUSH->IDLE edge + 1. This gives at least one m_valid-low bubble between bursts.
- Simultaneous events:
  - Capture and accept on the same edge leaves occupancy unchanged.
  - Writes during READ are ignored for burst length; they are counted toward the next burst.

## Configuration
- FIFO_BURST_READER_TIMEOUT_EN defined:
  - In IDLE, a timer counts cycles while 0 < fifo_count < BURST_LEN. The timer clears when fifo_count == 0 or on leaving IDLE.
  - When the timer reaches TIMEOUT_CYC, enter READ with burst_len_q = fifo_count. m_last marks the final sample of this short burst.
- Undefined: no timer. Partial data waits indefinitely until fifo_count >= BURST_LEN.

## Test plan
- Reset, then write 0x100..0x107 at one per cycle with m_ready=1 -> two bursts of 4: 0x100..0x103 with m_last on 0x103, and 0x104..0x107 with m_last on 0x107; bursts_done=2; first m_valid 2 edges after count reaches 4.
- Fill with 0x200..0x203, toggle m_ready every cycle -> data in order, no gaps or duplicates, m_data stable while stalled, never more than 2 pops ahead of accepts.
- Hold m_ready=0 with 8 samples queued -> exactly 2 pops then fifo_rd_en=0, fifo_count=6; release -> remaining samples stream, bursts_done=2.
- Assert reset after the second accept of a burst -> all outputs 0 in the same cycle, state IDLE, bursts_done=0, fifo_rd_en=0.
- With FIFO_BURST_READER_TIMEOUT_EN and TIMEOUT_CYC=64, write 3 samples 0x300..0x302 -> no output for 64 cycles, then a burst of 3 with m_last on 0x302; without the macro, no output ever.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the echo sample FIFO: pops fixed-length bursts and replays them
// on a valid/ready stream with m_last. Define FIFO_BURST_READER_TIMEOUT_EN to flush partial bursts.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  burst_active,
    output logic [15:0]           bursts_done
);

    localparam int unsigned   CW          = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_WIDTH)) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must lie in 1..2**ADDR_WIDTH");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           burst_len_q;
    logic [CW-1:0]           pops;
    logic [CW-1:0]           caps;
    logic                    inflight;
    logic [1:0]              occ;
    logic [1:0]              occ_after;
    logic [1:0]              occ_n;
    logic [2:0]              load;
    logic                    accept;
    logic                    start;
    logic [CW-1:0]           start_len;
    logic                    timeout_hit;
    logic                    last_pop;
    logic                    cap_last;
    logic                    burst_end;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [DATA_WIDTH-1:0]   tail_data;
    logic                    head_last;
    logic                    tail_last;
    logic [DATA_WIDTH-1:0]   head_data_n;
    logic [DATA_WIDTH-1:0]   tail_data_n;
    logic                    head_last_n;
    logic                    tail_last_n;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer;
    logic          partial;

    assign partial = (fifo_count != '0) && (fifo_count < BURST_LEN_C);

    // Timer saturates at TIMEOUT_CYC so a stalled partial burst keeps requesting the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state != IDLE || !partial) begin
            timer <= '0;
        end else if (timer != TW'(TIMEOUT_CYC)) begin
            timer <= timer + TW'(1);
        end
    end

    assign timeout_hit = partial && (timer == TW'(TIMEOUT_CYC));
    assign start_len   = (fifo_count >= BURST_LEN_C) ? BURST_LEN_C : fifo_count;
`else
    assign timeout_hit = 1'b0;
    assign start_len   = BURST_LEN_C;
`endif

    assign m_valid   = (occ != 2'd0);
    assign m_data    = head_data;
    assign m_last    = m_valid && head_last;
    assign accept    = m_valid && m_ready;
    assign occ_after = occ - {1'b0, accept};
    assign load      = {1'b0, occ_after} + {2'b00, inflight};
    assign occ_n     = occ_after + {1'b0, inflight};

    assign start     = (state == IDLE) && ((fifo_count >= BURST_LEN_C) || timeout_hit);
    assign last_pop  = fifo_rd_en && ((pops + CW'(1)) == burst_len_q);
    assign cap_last  = inflight && ((caps + CW'(1)) == burst_len_q);
    assign burst_end = (state == FLUSH) && accept && m_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)     state_next = READ;
            READ:    if (last_pop)  state_next = FLUSH;
            FLUSH:   if (burst_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Pops are throttled so buffered + in-flight samples never exceed the two skid slots.
    always_comb begin
        fifo_rd_en   = 1'b0;
        burst_active = (state != IDLE);
        if (state == READ && fifo_count != '0 && pops < burst_len_q && load < 3'd2) begin
            fifo_rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_len_q <= '0;
            pops        <= '0;
            caps        <= '0;
            inflight    <= 1'b0;
            bursts_done <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (start) begin
                burst_len_q <= start_len;
                pops        <= '0;
                caps        <= '0;
            end else begin
                if (fifo_rd_en) pops <= pops + CW'(1);
                if (inflight)   caps <= caps + CW'(1);
            end
            if (burst_end) bursts_done <= bursts_done + 16'd1;
        end
    end

    always_comb begin
        head_data_n = head_data;
        head_last_n = head_last;
        tail_data_n = tail_data;
        tail_last_n = tail_last;
        if (accept && occ == 2'd2) begin
            head_data_n = tail_data;
            head_last_n = tail_last;
        end
        // Arriving sample lands in the first slot left free after this cycle's accept.
        if (inflight) begin
            if (occ_after == 2'd0) begin
                head_data_n = fifo_data;
                head_last_n = cap_last;
            end else begin
                tail_data_n = fifo_data;
                tail_last_n = cap_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ       <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            occ       <= occ_n;
            head_data <= head_data_n;
            head_last <= head_last_n;
            tail_data <= tail_data_n;
            tail_last <= tail_last_n;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and a monitor
// checks the stream against the written sample order and the burst framing.
module tb_fifo_burst_reader;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned BL    = 4;
    localparam int unsigned TO    = 64;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   fifo_count = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          burst_active;
    logic [15:0]   bursts_done;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;
    int            exp_burst    = BL;
    int            pos          = 0;
    int            model_bursts = 0;
    logic          prev_stall   = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    bit seen;
    bit found;
    bit saw;
    int first_cyc;
    int ndrop;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_count  (fifo_count),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data   (fifo_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .burst_active(burst_active),
        .bursts_done (bursts_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, count already reflects this edge's pop and push.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            chk("no_underflow", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
            else                    fifo_data <= DW'($urandom);
        end else begin
            fifo_data <= DW'($urandom);
        end
        if (wr_en) begin
            fifo_q.push_back(wr_data);
            exp_q.push_back(wr_data);
        end
        fifo_count <= (AW+1)'(fifo_q.size());
    end

    // Monitor: samples away from the active edge; an accept seen here completes at the next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("bursts_done", bursts_done, model_bursts);
            chk("outstanding_le2", (exp_q.size() - fifo_q.size()) <= 2, 1);
            if (m_valid) chk("active_when_valid", burst_active, 1);
            if (!m_valid) chk("last_low_when_idle", m_last, 0);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                chk("sample_outstanding", (exp_q.size() - fifo_q.size()) > 0, 1);
                if (exp_q.size() > fifo_q.size()) begin
                    exp_d = exp_q.pop_front();
                    chk("m_data", m_data, exp_d);
                    chk("m_last", m_last, pos == exp_burst - 1);
                    if (pos == exp_burst - 1) begin
                        pos = 0;
                        model_bursts++;
                    end else begin
                        pos++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic write_one(input logic [DW-1:0] d);
        int g;
        g = 0;
        while (fifo_q.size() >= DEPTH && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g == 200) chk("write_room", fifo_q.size() < DEPTH, 1);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        bit done;
        g    = 0;
        done = 0;
        while (!done && g < 2000) begin
            @(negedge clk);
            done = !burst_active && (exp_q.size() == fifo_q.size()) && (fifo_q.size() < BL);
            g++;
        end
        chk(name, done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_active"}, burst_active, 0);
        chk({tag, "_bursts"}, bursts_done, 0);
    endtask

    initial begin
        reset   = 1'b1;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Two back-to-back bursts at full rate, with first-sample latency
        m_ready = 1'b1;
        fork
            for (int i = 0; i < 8; i++) write_one(DW'(16'h100 + i));
            begin
                seen = 0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (fifo_count >= BL) seen = 1;
                end
                chk("t1_count_reached", seen, 1);
                @(negedge clk);
                chk("t1_rd_en_after_E0", fifo_rd_en, 1);
                chk("t1_no_valid_E0p1", m_valid, 0);
                @(negedge clk);
                chk("t1_no_valid_E0p2", m_valid, 0);
                @(negedge clk);
                chk("t1_first_valid", m_valid, 1);
                chk("t1_first_data", m_data, 16'h100);
            end
        join
        drain("t1_drain");
        chk("t1_bursts_done", bursts_done, 2);
        chk("t1_fifo_empty", fifo_count, 0);

        // Toggling backpressure
        m_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++) write_one(DW'(16'h200 + i));
            for (int c = 0; c < 24; c++) begin
                @(posedge clk);
                #1 m_ready = ~m_ready;
            end
        join
        m_ready = 1'b1;
        drain("t2_drain");
        chk("t2_bursts_done", bursts_done, 3);

        // Held backpressure: only two pops may run ahead
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_one(DW'(16'h400 + i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_fifo_count", fifo_count, 6);
        chk("t3_rd_en_blocked", fifo_rd_en, 0);
        chk("t3_head_valid", m_valid, 1);
        @(posedge clk);
        #1 m_ready = 1'b1;
        drain("t3_drain");
        chk("t3_bursts_done", bursts_done, 5);

        // Reset after the second accept of a burst
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_one(DW'(16'h500 + i));
        m_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            #1;
            if (pos == 2) found = 1;
        end
        chk("t4_two_accepts", found, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("t4");
        ndrop = exp_q.size() - fifo_q.size();
        for (int i = 0; i < ndrop; i++) void'(exp_q.pop_front());
        pos          = 0;
        model_bursts = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        drain("t4_drain");
        chk("t4_bursts_done", bursts_done, 1);

        // Randomized writes and backpressure
        for (int c = 0; c < 400; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                wr_en   = 1'b1;
                wr_data = DW'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        wr_en   = 1'b0;
        m_ready = 1'b1;
        drain("t5_drain");
        if (fifo_q.size() > 0) begin
            ndrop = BL - fifo_q.size();
            for (int i = 0; i < ndrop; i++) write_one(DW'(16'hF00 + i));
            drain("t5_fill_drain");
        end
        chk("t5_fifo_empty", fifo_count, 0);

        // Partial burst of three samples
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        exp_burst = 3;
`endif
        for (int i = 0; i < 3; i++) write_one(DW'(16'h300 + i));
        saw       = 0;
        first_cyc = 0;
        for (int c = 0; c < 200 && !saw; c++) begin
            @(negedge clk);
            if (m_valid) begin
                saw       = 1;
                first_cyc = c;
            end
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        chk("t6_flush_seen", saw, 1);
        chk("t6_flush_not_early", first_cyc >= TO - 4, 1);
        @(posedge clk);
        #1;
        drain("t6_drain");
        chk("t6_fifo_empty", fifo_count, 0);
        exp_burst = BL;
`else
        chk("t6_no_partial_output", saw, 0);
        chk("t6_fifo_count", fifo_count, 3);
        chk("t6_idle", burst_active, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
